// File: rtl/add_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
package add_arb_pkg;

    typedef enum logic {
        MODE_BYTE  = 1'b0,
        MODE_SPLIT = 1'b1
    } mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_NREQ = 4;
    localparam int unsigned DEFAULT_W    = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr, circularly.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] mask;
    logic [2*NREQ-1:0] masked;

    always_comb begin
        int k;
        dbl = {req, req};
        // Upper copy is never masked, so the search always wraps around to index 0.
        for (int j = 0; j < 2 * NREQ; j++) begin
            mask[j] = (j > int'(last_ptr));
        end
        masked = dbl & mask;
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int j = 0; j < 2 * NREQ; j++) begin
            if (!any && masked[j]) begin
                any = 1'b1;
                k   = (j >= int'(NREQ)) ? j - int'(NREQ) : j;
                gnt[k] = 1'b1;
                idx    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/add_rr_arbiter.sv
// Round-robin shared adder with a single-entry valid/ready result register.
module add_rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ,
    parameter int unsigned W    = DEFAULT_W,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_flat,
    input  logic [NREQ*W-1:0] b_flat,
    input  logic [NREQ-1:0]   mode,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
    output logic              res_carry,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready
);

    state_e          state;
    logic [IDW-1:0]  last_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            slot_free;
    logic            grant;

    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    mode_e           mode_sel;
    logic [W:0]      sum;
    logic [W/2:0]    nib_sum;
    logic [W-1:0]    nxt_data;
    logic            nxt_carry;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign slot_free = (state == EMPTY) | res_ready;
    assign grant     = slot_free & pick_any & ~reset;
    assign gnt       = grant ? pick_gnt : '0;
    assign res_valid = (state == FULL);

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        mode_sel = MODE_BYTE;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                a_sel    = a_flat[i*W +: W];
                b_sel    = b_flat[i*W +: W];
                mode_sel = mode_e'(mode[i]);
            end
        end
        sum     = {1'b0, a_sel} + {1'b0, b_sel};
        nib_sum = {1'b0, a_sel[W-1:W/2]} + {1'b0, a_sel[W/2-1:0]};
        if (mode_sel == MODE_SPLIT) begin
            nxt_data  = {sum[W-1:W/2], nib_sum[W/2-1:0]};
            nxt_carry = nib_sum[W/2];
        end else begin
            nxt_data  = sum[W-1:0];
            nxt_carry = sum[W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            last_ptr  <= IDW'(NREQ - 1);
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
        end else begin
            if (grant) begin
                state     <= FULL;
                last_ptr  <= pick_idx;
                res_data  <= nxt_data;
                res_carry <= nxt_carry;
                res_id    <= pick_idx;
            end else if (state == FULL && res_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Randomized bench for add_rr_arbiter against a queue-free behavioural model.
module tb_add_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [W-1:0]      a_arr [NREQ];
    logic [W-1:0]      b_arr [NREQ];
    logic [NREQ*W-1:0] a_flat;
    logic [NREQ*W-1:0] b_flat;
    logic [NREQ-1:0]   mode = '0;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic              res_carry;
    logic [IDW-1:0]    res_id;
    logic              res_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    // model state
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_carry = 0;
    int m_id    = 0;
    int m_last  = NREQ - 1;
    int exp_g   = -1;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_flat[i*W +: W] = a_arr[i];
            b_flat[i*W +: W] = b_arr[i];
        end
    end

    add_rr_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .mode      (mode),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (reset) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void calc(input int i, output int d, output int c);
        int a, b, s, lo;
        a = int'(a_arr[i]);
        b = int'(b_arr[i]);
        s = a + b;
        if (mode[i]) begin
            lo = (a / 16) + (a % 16);
            d  = (s & 'hF0) | (lo % 16);
            c  = lo / 16;
        end else begin
            d = s % 256;
            c = s / 256;
        end
    endfunction

    // Compare process: outputs vs model on every falling edge.
    always @(negedge clk) begin
        int g;
        g = pick();
        check("gnt", int'(gnt), (g < 0) ? 0 : (1 << g));
        check("res_valid", int'(res_valid), int'(m_valid));
        if (m_valid || reset) begin
            check("res_data", int'(res_data), m_data);
            check("res_carry", int'(res_carry), m_carry);
            check("res_id", int'(res_id), m_id);
        end
        exp_g <= g;
    end

    always @(posedge clk or posedge reset) begin
        int d, c;
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 0;
            m_carry <= 0;
            m_id    <= 0;
            m_last  <= NREQ - 1;
        end else if (exp_g >= 0) begin
            calc(exp_g, d, c);
            m_valid <= 1'b1;
            m_data  <= d;
            m_carry <= c;
            m_id    <= exp_g;
            m_last  <= exp_g;
        end else if (res_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        #1 reset = 1'b1;
        #1 check("reset_valid", int'(res_valid), 0);
        check("reset_gnt", int'(gnt), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single byte add from requester 0
        req = 4'b0001; a_arr[0] = 8'h3C; b_arr[0] = 8'h05; mode = '0; res_ready = 1'b1;
        #1 check("t1_gnt", int'(gnt), 1);
        tick();
        check("t1_valid", int'(res_valid), 1);
        check("t1_data", int'(res_data), 'h41);
        check("t1_carry", int'(res_carry), 0);
        check("t1_id", int'(res_id), 0);

        // fairness from a fresh pointer
        req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) a_arr[i] = W'($urandom);
            #1 check("rr_gnt", int'(gnt), 1 << (k % NREQ));
            tick();
            check("rr_id", int'(res_id), k % NREQ);
        end

        // split mode, requester 2
        req = 4'b0100; mode = 4'b0100; a_arr[2] = 8'h9A; b_arr[2] = 8'h17;
        #1 check("split_gnt", int'(gnt), 4);
        tick();
        check("split_data", int'(res_data), 'hB3);
        check("split_carry", int'(res_carry), 1);
        check("split_id", int'(res_id), 2);

        // byte overflow on requester 0
        req = 4'b0001; mode = '0; a_arr[0] = 8'hFF; b_arr[0] = 8'h01;
        tick();
        check("ovf_data", int'(res_data), 0);
        check("ovf_carry", int'(res_carry), 1);

        // backpressure with pending 1 and 2
        req = 4'b0110; res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("stall_gnt", int'(gnt), 0);
            check("stall_data", int'(res_data), 0);
            check("stall_id", int'(res_id), 0);
            tick();
        end
        res_ready = 1'b1;
        #1 check("resume_gnt1", int'(gnt), 2);
        tick();
        check("resume_id1", int'(res_id), 1);
        #1 check("resume_gnt2", int'(gnt), 4);
        tick();
        check("resume_id2", int'(res_id), 2);

        // reset while full with pending requests
        req = 4'b1111; res_ready = 1'b0;
        #1 reset = 1'b1;
        #1 check("midrst_valid", int'(res_valid), 0);
        check("midrst_gnt", int'(gnt), 0);
        tick();
        reset = 1'b0; req = 4'b1000; res_ready = 1'b1;
        tick();
        check("postrst_id", int'(res_id), 3);

        // reset with all requesting, first grant goes to 0
        req = 4'b1111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("rst_first_gnt", int'(gnt), 1);
        tick();
        check("rst_first_id", int'(res_id), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req       = NREQ'($urandom);
            mode      = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = W'($urandom);
                b_arr[i] = W'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        req   = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
